// File: rtl/cmt_pkg.sv
// Shared constants and types for the cassette FSK receiver.
// Cycle-length thresholds are rounded clock counts derived from the system clock rate.
package cmt_pkg;

    localparam int CLK_HZ_DEF    = 50_000_000;
    localparam int CARRIER_N_DEF = 16;

    // Frequencies bounding a valid tone cycle and splitting mark from space
    localparam int HZ_MIN   = 3000;
    localparam int HZ_SPLIT = 1800;
    localparam int HZ_MAX   = 900;

    function automatic int per_clk(input int clk_hz, input int hz);
        return (clk_hz + hz / 2) / hz;
    endfunction

    localparam int PER_MIN_DEF   = per_clk(CLK_HZ_DEF, HZ_MIN);
    localparam int PER_SPLIT_DEF = per_clk(CLK_HZ_DEF, HZ_SPLIT);
    localparam int PER_MAX_DEF   = per_clk(CLK_HZ_DEF, HZ_MAX);

    typedef enum logic [1:0] {
        MARK    = 2'd0,
        SPACE   = 2'd1,
        INVALID = 2'd2
    } tone_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        STOP1 = 2'd2,
        STOP2 = 2'd3
    } frame_state_t;

endpackage

// File: rtl/cmt_fsk_receiver_if.sv
// CPU-side CMT GPIO view: firmware drives enable/ack and polls the byte and status bits.
// No handshake backpressure; ack is a single-cycle pulse that clears the sticky flags.
interface cmt_fsk_receiver_if;
    logic       enable;
    logic       ack;
    logic [7:0] data_out;
    logic       ready;
    logic       overrun;
    logic       frame_err;
    logic       carrier;

    modport master (
        output enable, ack,
        input  data_out, ready, overrun, frame_err, carrier
    );

    modport slave (
        input  enable, ack,
        output data_out, ready, overrun, frame_err, carrier
    );
endinterface

// File: rtl/cmt_period_classifier.sv
// Synchronises cmt_in, measures rise-to-rise cycle length and labels each cycle mark/space/invalid.
// Outputs are registered pulses 3 clk after the cmt_in edge; no backpressure, results are not held.
module cmt_period_classifier
    import cmt_pkg::*;
#(
    parameter int PER_MIN   = PER_MIN_DEF,
    parameter int PER_SPLIT = PER_SPLIT_DEF,
    parameter int PER_MAX   = PER_MAX_DEF,
    parameter int CARRIER_N = CARRIER_N_DEF
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  cmt_in,
    input  logic  enable,
    output logic  tone_valid,
    output tone_t tone,
    output logic  invalid,
    output logic  carrier
);

    localparam int              CW       = $clog2(CARRIER_N + 1);
    localparam logic [15:0]     MIN_C    = 16'(PER_MIN);
    localparam logic [15:0]     SPLIT_C  = 16'(PER_SPLIT);
    localparam logic [15:0]     MAX_C    = 16'(PER_MAX);
    localparam logic [CW-1:0]   CAR_FULL = CW'(CARRIER_N);

    logic          sync1, sync2, dly;
    logic          rise;
    logic [15:0]   per_cnt;
    logic          have_ref;
    logic [CW-1:0] car_cnt;
    tone_t         tone_c;

    assign rise    = sync2 & ~dly;
    assign carrier = (car_cnt == CAR_FULL);

    always_comb begin
        tone_c = SPACE;
        if (per_cnt < MIN_C || per_cnt >= MAX_C)
            tone_c = INVALID;
        else if (per_cnt < SPLIT_C)
            tone_c = MARK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
        end else begin
            sync1 <= cmt_in;
            sync2 <= sync1;
            dly   <= sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt    <= '0;
            have_ref   <= 1'b0;
            car_cnt    <= '0;
            tone_valid <= 1'b0;
            invalid    <= 1'b0;
            tone       <= MARK;
        end else if (!enable) begin
            per_cnt    <= '0;
            have_ref   <= 1'b0;
            car_cnt    <= '0;
            tone_valid <= 1'b0;
            invalid    <= 1'b0;
        end else begin
            tone_valid <= 1'b0;
            invalid    <= 1'b0;
            if (rise) begin
                per_cnt  <= 16'd1;
                have_ref <= 1'b1;
                // The first edge after a restart only opens the measurement window
                if (have_ref) begin
                    tone <= tone_c;
                    if (tone_c == INVALID) begin
                        invalid <= 1'b1;
                        car_cnt <= '0;
                    end else begin
                        tone_valid <= 1'b1;
                        if (car_cnt != CAR_FULL)
                            car_cnt <= car_cnt + 1'b1;
                    end
                end
            end else if (per_cnt == MAX_C - 16'd1) begin
                per_cnt  <= MAX_C;
                have_ref <= 1'b0;
                invalid  <= 1'b1;
                car_cnt  <= '0;
                tone     <= INVALID;
            end else if (per_cnt != MAX_C) begin
                per_cnt <= per_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/cmt_fsk_receiver.sv
// Turns FSK tone cycles into bits, frames 8N2 LSB-first bytes and holds them for firmware polling.
// ready rises 4 clk after the completing cmt_in edge; no backpressure, an unread byte is overwritten (overrun).
module cmt_fsk_receiver
    import cmt_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEF,
    parameter int CARRIER_N = CARRIER_N_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmt_in,
    cmt_fsk_receiver_if.slave  gpio
);

    localparam int PER_MIN   = per_clk(CLK_HZ, HZ_MIN);
    localparam int PER_SPLIT = per_clk(CLK_HZ, HZ_SPLIT);
    localparam int PER_MAX   = per_clk(CLK_HZ, HZ_MAX);

    logic         tone_valid, invalid, carrier;
    tone_t        tone;

    tone_t        acc_tone;
    logic [2:0]   acc_cnt, next_cnt;
    logic         bit_vld, bit_val;

    frame_state_t state;
    logic [2:0]   bit_idx;
    logic [7:0]   shreg;
    logic [7:0]   data_q;
    logic         ready_q, overrun_q, frame_err_q;
    logic         deliver, ferr;

    cmt_period_classifier #(
        .PER_MIN   (PER_MIN),
        .PER_SPLIT (PER_SPLIT),
        .PER_MAX   (PER_MAX),
        .CARRIER_N (CARRIER_N)
    ) u_classifier (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmt_in     (cmt_in),
        .enable     (gpio.enable),
        .tone_valid (tone_valid),
        .tone       (tone),
        .invalid    (invalid),
        .carrier    (carrier)
    );

    // Four mark cycles or two space cycles make one bit cell
    always_comb begin
        next_cnt = 3'd1;
        if (tone == acc_tone)
            next_cnt = acc_cnt + 3'd1;
        bit_val = (tone == MARK);
        bit_vld = tone_valid && gpio.enable &&
                  ((tone == MARK && next_cnt == 3'd4) || (tone == SPACE && next_cnt == 3'd2));
    end

    assign deliver = bit_vld &&  bit_val && (state == STOP2);
    assign ferr    = bit_vld && !bit_val && (state == STOP1 || state == STOP2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_tone <= MARK;
            acc_cnt  <= 3'd0;
        end else if (!gpio.enable || invalid) begin
            acc_tone <= MARK;
            acc_cnt  <= 3'd0;
        end else if (tone_valid) begin
            acc_tone <= tone;
            acc_cnt  <= bit_vld ? 3'd0 : next_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            data_q      <= 8'h00;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // ack takes effect before a coincident delivery or framing error
            ready_q     <= deliver | (ready_q & ~gpio.ack);
            overrun_q   <= (overrun_q & ~gpio.ack) | (deliver & ready_q & ~gpio.ack);
            frame_err_q <= (frame_err_q & ~gpio.ack) | ferr;
            if (deliver)
                data_q <= shreg;

            if (!gpio.enable || invalid) begin
                state   <= IDLE;
                bit_idx <= 3'd0;
            end else if (bit_vld) begin
                case (state)
                    IDLE: begin
                        if (!bit_val) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {bit_val, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP1;
                    end
                    STOP1:   state <= bit_val ? STOP2 : IDLE;
                    STOP2:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign gpio.data_out  = data_q;
    assign gpio.ready     = ready_q;
    assign gpio.overrun   = overrun_q;
    assign gpio.frame_err = frame_err_q;
    assign gpio.carrier   = carrier;

endmodule

// File: tb/tb_cmt_fsk_receiver.sv
// Directed bench for cmt_fsk_receiver at a scaled clock rate (96 kHz: mark cycle 40 clk, space 80 clk).
module tb_cmt_fsk_receiver;

    localparam int TB_CLK_HZ = 96000;
    localparam int MP = 40;
    localparam int SP = 80;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic cmt_in  = 1'b0;

    int checks   = 0;
    int failures = 0;

    cmt_fsk_receiver_if gpio ();

    cmt_fsk_receiver #(
        .CLK_HZ    (TB_CLK_HZ),
        .CARRIER_N (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cmt_in  (cmt_in),
        .gpio    (gpio)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One FSK cycle of p clocks, rising edge first; starts and ends on a negedge
    task automatic cyc(input int p);
        cmt_in = 1'b1;
        repeat (p / 2) @(negedge clk);
        cmt_in = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    task automatic idle(input int n, input int mp);
        repeat (n) cyc(mp);
    endtask

    task automatic tone_bit(input logic b, input int mp, input int sp);
        if (b) repeat (4) cyc(mp);
        else   repeat (2) cyc(sp);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop2, input int mp, input int sp);
        tone_bit(1'b0, mp, sp);
        for (int i = 0; i < 8; i++) tone_bit(d[i], mp, sp);
        tone_bit(1'b1, mp, sp);
        tone_bit(stop2, mp, sp);
    endtask

    task automatic ack_pulse();
        gpio.ack = 1'b1;
        @(negedge clk);
        gpio.ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        gpio.enable = 1'b0;
        gpio.ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data",    gpio.data_out,  8'h00);
        check("rst_ready",   gpio.ready,     1'b0);
        check("rst_overrun", gpio.overrun,   1'b0);
        check("rst_ferr",    gpio.frame_err, 1'b0);
        check("rst_carrier", gpio.carrier,   1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        gpio.enable = 1'b1;

        // Idle mark tone brings up carrier, then 0xA5 with exact ready latency
        idle(20, MP);
        check("carrier_up", gpio.carrier, 1'b1);
        send_byte(8'hA5, 1'b1, MP, SP);
        cmt_in = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_early", gpio.ready, 1'b0);
        @(negedge clk);
        check("lat_ready", gpio.ready,     1'b1);
        check("a5_data",   gpio.data_out,  8'hA5);
        check("a5_ovr",    gpio.overrun,   1'b0);
        check("a5_ferr",   gpio.frame_err, 1'b0);
        repeat (MP / 2 - 4) @(negedge clk);
        cmt_in = 1'b0;
        repeat (MP / 2) @(negedge clk);
        ack_pulse();
        check("a5_ack_ready", gpio.ready,    1'b0);
        check("a5_ack_data",  gpio.data_out, 8'hA5);

        // Back-to-back bytes without ack
        idle(2, MP);
        send_byte(8'h3C, 1'b1, MP, SP);
        send_byte(8'h81, 1'b1, MP, SP);
        idle(2, MP);
        check("ovr_data",  gpio.data_out, 8'h81);
        check("ovr_ready", gpio.ready,    1'b1);
        check("ovr_flag",  gpio.overrun,  1'b1);
        ack_pulse();
        check("ovr_ack_ready", gpio.ready,     1'b0);
        check("ovr_ack_ovr",   gpio.overrun,   1'b0);
        check("ovr_ack_ferr",  gpio.frame_err, 1'b0);

        // Second stop bit sent as space
        send_byte(8'h55, 1'b0, MP, SP);
        idle(2, MP);
        check("ferr_flag",  gpio.frame_err, 1'b1);
        check("ferr_ready", gpio.ready,     1'b0);
        check("ferr_data",  gpio.data_out,  8'h81);
        send_byte(8'h00, 1'b1, MP, SP);
        idle(2, MP);
        check("after_ferr_data",  gpio.data_out,  8'h00);
        check("after_ferr_ready", gpio.ready,     1'b1);
        check("after_ferr_sticky", gpio.frame_err, 1'b1);
        ack_pulse();
        check("ferr_ack", gpio.frame_err, 1'b0);

        // Glitch in the middle of 0xFF data bits
        idle(2, MP);
        tone_bit(1'b0, MP, SP);
        for (int i = 0; i < 4; i++) tone_bit(1'b1, MP, SP);
        check("pre_glitch_carrier", gpio.carrier, 1'b1);
        cmt_in = 1'b1; repeat (20) @(negedge clk);
        cmt_in = 1'b0; repeat (10) @(negedge clk);
        cmt_in = 1'b1; repeat (3)  @(negedge clk);
        cmt_in = 1'b0; repeat (7)  @(negedge clk);
        check("glitch_carrier", gpio.carrier, 1'b0);
        idle(24, MP);
        check("glitch_no_ready", gpio.ready,   1'b0);
        check("glitch_recover",  gpio.carrier, 1'b1);
        send_byte(8'h12, 1'b1, MP, SP);
        idle(2, MP);
        check("glitch_next_data",  gpio.data_out, 8'h12);
        check("glitch_next_ready", gpio.ready,    1'b1);
        ack_pulse();

        // Tone frequencies off by 10% in both directions
        idle(4, 44);
        send_byte(8'hC3, 1'b1, 44, 89);
        idle(2, 44);
        check("slow_data", gpio.data_out, 8'hC3);
        check("slow_ovr",  gpio.overrun,  1'b0);
        ack_pulse();
        idle(4, 36);
        send_byte(8'h5A, 1'b1, 36, 73);
        idle(2, 36);
        check("fast_data",  gpio.data_out, 8'h5A);
        check("fast_ready", gpio.ready,    1'b1);
        ack_pulse();

        // Overlong cycle mid-frame drops carrier and abandons the frame
        idle(2, MP);
        tone_bit(1'b0, MP, SP);
        tone_bit(1'b1, MP, SP);
        tone_bit(1'b0, MP, SP);
        tone_bit(1'b1, MP, SP);
        cyc(120);
        check("timeout_carrier", gpio.carrier, 1'b0);
        idle(20, MP);
        check("timeout_no_ready", gpio.ready, 1'b0);
        send_byte(8'h99, 1'b1, MP, SP);
        idle(2, MP);
        check("timeout_next_data",  gpio.data_out, 8'h99);
        check("timeout_next_ready", gpio.ready,    1'b1);

        // Asynchronous reset mid-DATA
        idle(2, MP);
        tone_bit(1'b0, MP, SP);
        tone_bit(1'b1, MP, SP);
        tone_bit(1'b0, MP, SP);
        reset_n = 1'b0;
        #1;
        check("arst_data",    gpio.data_out, 8'h00);
        check("arst_ready",   gpio.ready,    1'b0);
        check("arst_carrier", gpio.carrier,  1'b0);
        cmt_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idle(20, MP);
        send_byte(8'h7E, 1'b1, MP, SP);
        idle(2, MP);
        check("post_rst_data",  gpio.data_out, 8'h7E);
        check("post_rst_ready", gpio.ready,    1'b1);

        // ack coinciding with delivery while ready and overrun are set
        send_byte(8'h11, 1'b1, MP, SP);
        idle(1, MP);
        check("pre_ack_ovr", gpio.overrun, 1'b1);
        send_byte(8'h42, 1'b1, MP, SP);
        cmt_in = 1'b1;
        repeat (3) @(negedge clk);
        gpio.ack = 1'b1;
        @(negedge clk);
        gpio.ack = 1'b0;
        check("coinc_ready", gpio.ready,    1'b1);
        check("coinc_ovr",   gpio.overrun,  1'b0);
        check("coinc_data",  gpio.data_out, 8'h42);
        repeat (MP / 2 - 4) @(negedge clk);
        cmt_in = 1'b0;
        repeat (MP / 2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
